// File: rtl/mips_pkg.sv
// Shared MIPS core definitions: opcodes, data-memory access sizes and the
// per-stage record used by the data-memory read pipeline.
package mips_pkg;

    typedef enum logic [5:0] {
        R_TYPE = 6'b000000,
        J      = 6'b000010,
        JAL    = 6'b000011,
        BEQ    = 6'b000100,
        BNE    = 6'b000101,
        ADDI   = 6'b001000,
        LB     = 6'b100000,
        LH     = 6'b100001,
        LW     = 6'b100011,
        LBU    = 6'b100100,
        LHU    = 6'b100101,
        SB     = 6'b101000,
        SH     = 6'b101001,
        SW     = 6'b101011
    } t_opcode;

    typedef enum logic [1:0] {
        SIZE_B   = 2'b00,
        SIZE_H   = 2'b01,
        SIZE_W   = 2'b10,
        SIZE_RSV = 2'b11
    } t_mem_size;

    typedef struct packed {
        logic        valid;
        logic [31:0] rdata;
        logic        err;
    } t_dmem_stage;

    // Reserved size reports 4 so the range check stays well defined; it errors anyway.
    function automatic logic [2:0] size_bytes(t_mem_size size);
        case (size)
            SIZE_B:  return 3'd1;
            SIZE_H:  return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/mips_dmem_if.sv
// Request/response channel between the MEM stage and the data memory.
interface mips_dmem_if #(
    parameter int ADDR_W = 32
);
    import mips_pkg::*;

    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    t_mem_size         req_size;
    logic              req_unsigned;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [31:0]       rsp_rdata;
    logic              rsp_err;

    modport master (
        output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );

endinterface

// File: rtl/mips_dmem_align.sv
// Byte-lane steering: store byte enables/lane data, load extraction and
// extension, and the alignment check for half and word accesses.
module mips_dmem_align
    import mips_pkg::*;
(
    input  t_mem_size   size,
    input  logic [1:0]  addr_lo,
    input  logic        is_unsigned,
    input  logic [31:0] wdata,
    input  logic [31:0] raw_word,
    output logic [3:0]  byte_en,
    output logic [31:0] wdata_lane,
    output logic [31:0] rdata_ext,
    output logic        misaligned
);

    logic [31:0] shifted;

    assign shifted = raw_word >> {addr_lo, 3'b000};

    // NOTE: every output gets a default first so no path through the case infers a latch.
    always_comb begin
        byte_en    = 4'b0000;
        wdata_lane = 32'h0;
        rdata_ext  = 32'h0;
        misaligned = 1'b0;
        case (size)
            SIZE_B: begin
                byte_en    = 4'(4'b0001 << addr_lo);
                wdata_lane = {4{wdata[7:0]}};
                rdata_ext  = is_unsigned ? {24'h0, shifted[7:0]}
                                         : {{24{shifted[7]}}, shifted[7:0]};
            end
            SIZE_H: begin
                byte_en    = 4'(4'b0011 << addr_lo);
                wdata_lane = {2{wdata[15:0]}};
                rdata_ext  = is_unsigned ? {16'h0, shifted[15:0]}
                                         : {{16{shifted[15]}}, shifted[15:0]};
                misaligned = addr_lo[0];
            end
            SIZE_W: begin
                byte_en    = 4'b1111;
                wdata_lane = wdata;
                rdata_ext  = raw_word;
                misaligned = (addr_lo != 2'b00);
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mips_dmem.sv
// MEM-stage data memory: word array with byte-lane writes, error detection at
// accept, and an RD_LAT-deep response pipeline that stalls as one unit.
module mips_dmem
    import mips_pkg::*;
#(
    parameter int DEPTH_BYTES = 128,
    parameter int ADDR_W      = 32,
    parameter int RD_LAT      = 1
) (
    input logic          clk,
    input logic          rst,
    mips_dmem_if.slave   bus
);

    localparam int IDX_W  = $clog2(DEPTH_BYTES);
    localparam int WORDS  = DEPTH_BYTES / 4;
    localparam int WIDX_W = (IDX_W > 2) ? IDX_W - 2 : 1;
    localparam logic [ADDR_W:0] DEPTH_EXT = (ADDR_W + 1)'(DEPTH_BYTES);

    logic [31:0]       mem [WORDS];
    t_dmem_stage       stage_q [RD_LAT];

    logic              advance;
    logic              accept;
    logic [WIDX_W-1:0] word_idx;
    logic [31:0]       raw_word;
    logic [3:0]        byte_en;
    logic [31:0]       wdata_lane;
    logic [31:0]       rdata_ext;
    logic              misaligned;
    logic [ADDR_W:0]   last_ok;
    logic              out_of_range;
    logic              req_err;

    assign advance       = !stage_q[RD_LAT-1].valid || bus.rsp_ready;
    assign bus.req_ready = advance && !rst;
    assign accept        = bus.req_valid && bus.req_ready;

    assign word_idx = bus.req_addr[2 +: WIDX_W];
    assign raw_word = mem[word_idx];

    // Full-width compare, so any set address bit above the array also lands here.
    assign last_ok      = DEPTH_EXT - {{(ADDR_W - 2){1'b0}}, size_bytes(bus.req_size)};
    assign out_of_range = {1'b0, bus.req_addr} > last_ok;
    assign req_err      = misaligned || out_of_range || (bus.req_size == SIZE_RSV);

    mips_dmem_align u_align (
        .size        (bus.req_size),
        .addr_lo     (bus.req_addr[1:0]),
        .is_unsigned (bus.req_unsigned),
        .wdata       (bus.req_wdata),
        .raw_word    (raw_word),
        .byte_en     (byte_en),
        .wdata_lane  (wdata_lane),
        .rdata_ext   (rdata_ext),
        .misaligned  (misaligned)
    );

    // NOTE: the array has no reset; its contents survive rst and only the pipeline is cleared.
    always_ff @(posedge clk) begin
        if (accept && bus.req_write && !req_err) begin
            for (int b = 0; b < 4; b++) begin
                if (byte_en[b]) begin
                    mem[word_idx][8*b +: 8] <= wdata_lane[8*b +: 8];
                end
            end
        end
    end

    // NOTE: state uses non-blocking assignments so all stages shift on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < RD_LAT; i++) begin
                stage_q[i] <= '0;
            end
        end else if (advance) begin
            stage_q[0].valid <= accept;
            stage_q[0].rdata <= (accept && !bus.req_write && !req_err) ? rdata_ext : 32'h0;
            stage_q[0].err   <= accept && req_err;
            for (int i = 1; i < RD_LAT; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign bus.rsp_valid = stage_q[RD_LAT-1].valid;
    assign bus.rsp_rdata = stage_q[RD_LAT-1].rdata;
    assign bus.rsp_err   = stage_q[RD_LAT-1].err;

endmodule

// File: tb/tb_mips_dmem.sv
// Self-checking bench for mips_dmem: directed cases plus randomized traffic
// scored against a byte-array reference model.
module tb_mips_dmem;
    import mips_pkg::*;

    localparam int DEPTH  = 128;
    localparam int ADDR_W = 32;
    localparam int RD_LAT = 3;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          cyc;
        bit          chk_lat;
        bit          has_want;
        logic [31:0] want;
        logic        want_err;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    bit   rand_bp = 1'b0;

    logic [7:0]  model_mem [DEPTH];
    exp_t        exp_q [$];
    bit          held_v = 1'b0;
    logic [31:0] held_rdata;
    logic        held_err;

    mips_dmem_if #(.ADDR_W(ADDR_W)) bus ();

    mips_dmem #(.DEPTH_BYTES(DEPTH), .ADDR_W(ADDR_W), .RD_LAT(RD_LAT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    // Reference: little-endian byte array, rules applied directly.
    function automatic void model_access(input bit wr, input t_mem_size sz, input bit uns,
                                         input logic [31:0] addr, input logic [31:0] wd,
                                         output logic [31:0] rd, output logic er);
        int n;
        logic [31:0] v;
        n  = (sz == SIZE_B) ? 1 : (sz == SIZE_H) ? 2 : 4;
        er = (sz == SIZE_RSV) || (addr % n != 0) || (64'(addr) > 64'(DEPTH - n));
        rd = 32'h0;
        if (!er) begin
            if (wr) begin
                for (int i = 0; i < n; i++) model_mem[addr + i] = wd[8*i +: 8];
            end else begin
                v = 32'h0;
                for (int i = 0; i < n; i++) v = v | (32'(model_mem[addr + i]) << (8 * i));
                if (!uns && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8 * n));
                rd = v;
            end
        end
    endfunction

    task automatic xfer(bit wr, t_mem_size sz, bit uns, logic [31:0] addr, logic [31:0] wd,
                        bit has_want, logic [31:0] want, logic want_err, bit chk_lat);
        int   waited = 0;
        bit   ok = 1'b0;
        exp_t e;
        bus.req_valid    = 1'b1;
        bus.req_write    = wr;
        bus.req_size     = sz;
        bus.req_unsigned = uns;
        bus.req_addr     = addr;
        bus.req_wdata    = wd;
        while (waited < 64) begin
            if (rand_bp) bus.rsp_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            if (bus.req_ready) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
            waited++;
        end
        check("req_accept_timeout", 32'(waited), 32'(ok ? waited : 0));
        if (ok) begin
            model_access(wr, sz, uns, addr, wd, e.rdata, e.err);
            e.cyc      = cyc;
            e.chk_lat  = chk_lat;
            e.has_want = has_want;
            e.want     = want;
            e.want_err = want_err;
            exp_q.push_back(e);
            @(posedge clk);
            #1;
        end
        bus.req_valid = 1'b0;
    endtask

    task automatic op(bit wr, t_mem_size sz, bit uns, logic [31:0] addr, logic [31:0] wd);
        xfer(wr, sz, uns, addr, wd, 1'b0, 32'h0, 1'b0, 1'b0);
    endtask

    task automatic op_want(bit wr, t_mem_size sz, bit uns, logic [31:0] addr,
                           logic [31:0] wd, logic [31:0] want, logic want_err);
        xfer(wr, sz, uns, addr, wd, 1'b1, want, want_err, 1'b0);
    endtask

    task automatic idle(int n);
        bus.req_valid = 1'b0;
        repeat (n) begin
            if (rand_bp) bus.rsp_ready = ($urandom_range(0, 3) != 0);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drain();
        int n = 0;
        bus.req_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        while (exp_q.size() != 0 && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("drain_leftover", 32'(exp_q.size()), 32'd0);
    endtask

    // Response scoreboard plus hold-stability under back-pressure.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            held_v = 1'b0;
        end else begin
            if (bus.rsp_valid && !bus.rsp_ready) begin
                if (held_v) begin
                    check("hold_rdata", bus.rsp_rdata, held_rdata);
                    check("hold_err", 32'(bus.rsp_err), 32'(held_err));
                end
                held_v     = 1'b1;
                held_rdata = bus.rsp_rdata;
                held_err   = bus.rsp_err;
            end else begin
                held_v = 1'b0;
            end
            if (bus.rsp_valid && bus.rsp_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_rsp", 32'(bus.rsp_valid), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("rsp_rdata", bus.rsp_rdata, e.rdata);
                    check("rsp_err", 32'(bus.rsp_err), 32'(e.err));
                    if (e.has_want) begin
                        check("directed_rdata", bus.rsp_rdata, e.want);
                        check("directed_err", 32'(bus.rsp_err), 32'(e.want_err));
                    end
                    if (e.chk_lat) check("latency", 32'(cyc - e.cyc), 32'(RD_LAT));
                end
            end
        end
    end

    initial begin
        bus.req_valid    = 1'b0;
        bus.req_write    = 1'b0;
        bus.req_size     = SIZE_W;
        bus.req_unsigned = 1'b0;
        bus.req_addr     = 32'h0;
        bus.req_wdata    = 32'h0;
        bus.rsp_ready    = 1'b1;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("reset_rsp_rdata", bus.rsp_rdata, 32'h0);
        check("reset_rsp_err", 32'(bus.rsp_err), 32'd0);
        check("reset_req_ready", 32'(bus.req_ready), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Give every word a defined value
        for (int w = 0; w < DEPTH / 4; w++) op(1'b1, SIZE_W, 1'b0, 32'(4 * w), $urandom);
        drain();

        // SW then LW back-to-back, with latency check
        op_want(1'b1, SIZE_W, 1'b0, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0);
        xfer(1'b0, SIZE_W, 1'b0, 32'h10, 32'h0, 1'b1, 32'hDEADBEEF, 1'b0, 1'b1);
        drain();

        // Sub-word loads with extension
        op_want(1'b0, SIZE_B, 1'b0, 32'h13, 32'h0, 32'hFFFFFFDE, 1'b0);
        op_want(1'b0, SIZE_B, 1'b1, 32'h13, 32'h0, 32'h000000DE, 1'b0);
        op_want(1'b0, SIZE_H, 1'b0, 32'h10, 32'h0, 32'hFFFFBEEF, 1'b0);
        op_want(1'b0, SIZE_H, 1'b1, 32'h12, 32'h0, 32'h0000DEAD, 1'b0);

        // Byte store touches one lane only
        op(1'b1, SIZE_B, 1'b0, 32'h11, 32'hCAFE0055);
        op_want(1'b0, SIZE_W, 1'b0, 32'h10, 32'h0, 32'hDEAD55EF, 1'b0);

        // Errors and range boundaries
        op_want(1'b0, SIZE_W, 1'b0, 32'h12, 32'h0, 32'h0, 1'b1);
        op_want(1'b1, SIZE_H, 1'b0, 32'h11, 32'h00001234, 32'h0, 1'b1);
        op_want(1'b0, SIZE_W, 1'b0, 32'h10, 32'h0, 32'hDEAD55EF, 1'b0);
        op_want(1'b0, SIZE_W, 1'b0, 32'(DEPTH - 2), 32'h0, 32'h0, 1'b1);
        op_want(1'b0, SIZE_RSV, 1'b0, 32'h0, 32'h0, 32'h0, 1'b1);
        op_want(1'b0, SIZE_W, 1'b0, 32'(DEPTH), 32'h0, 32'h0, 1'b1);
        op_want(1'b0, SIZE_B, 1'b0, 32'(DEPTH), 32'h0, 32'h0, 1'b1);
        op_want(1'b0, SIZE_W, 1'b0, 32'h8000_0010, 32'h0, 32'h0, 1'b1);
        op_want(1'b1, SIZE_W, 1'b0, 32'(DEPTH - 4), 32'h8899AABB, 32'h0, 1'b0);
        op_want(1'b0, SIZE_B, 1'b1, 32'(DEPTH - 1), 32'h0, 32'h00000088, 1'b0);
        op_want(1'b0, SIZE_H, 1'b0, 32'(DEPTH - 2), 32'h0, 32'hFFFF8899, 1'b0);
        drain();

        // Back-to-back traffic, then output held for 3 cycles
        op(1'b1, SIZE_W, 1'b0, 32'h20, 32'hA5A50001);
        op(1'b0, SIZE_W, 1'b0, 32'h20, 32'h0);
        op(1'b1, SIZE_W, 1'b0, 32'h24, 32'h0BADF00D);
        op(1'b0, SIZE_W, 1'b0, 32'h24, 32'h0);
        bus.rsp_ready    = 1'b0;
        bus.req_valid    = 1'b1;
        bus.req_write    = 1'b1;
        bus.req_size     = SIZE_W;
        bus.req_addr     = 32'h28;
        bus.req_wdata    = 32'h13579BDF;
        repeat (3) begin
            @(negedge clk);
            check("stall_req_ready", 32'(bus.req_ready), 32'd0);
            check("stall_rsp_valid", 32'(bus.rsp_valid), 32'd1);
            @(posedge clk);
            #1;
        end
        bus.rsp_ready = 1'b1;
        op(1'b1, SIZE_W, 1'b0, 32'h28, 32'h13579BDF);
        op_want(1'b0, SIZE_W, 1'b0, 32'h28, 32'h0, 32'h13579BDF, 1'b0);
        drain();

        // Reset with loads in flight
        op(1'b1, SIZE_W, 1'b0, 32'h40, 32'h12345678);
        op(1'b0, SIZE_W, 1'b0, 32'h40, 32'h0);
        op(1'b0, SIZE_W, 1'b0, 32'h10, 32'h0);
        rst = 1'b1;
        exp_q.delete();
        @(negedge clk);
        check("rst_req_ready", 32'(bus.req_ready), 32'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("rst_rsp_rdata", bus.rsp_rdata, 32'h0);
        @(posedge clk);
        #1 rst = 1'b0;
        idle(2 * RD_LAT + 2);
        op_want(1'b0, SIZE_W, 1'b0, 32'h40, 32'h0, 32'h12345678, 1'b0);
        drain();

        // Randomized traffic with random back-pressure
        rand_bp = 1'b1;
        for (int k = 0; k < 300; k++) begin
            int          r;
            logic [31:0] a;
            t_mem_size   sz;
            r  = $urandom_range(0, 9);
            sz = (r < 3) ? SIZE_B : (r < 6) ? SIZE_H : (r < 9) ? SIZE_W : SIZE_RSV;
            a  = 32'($urandom_range(0, DEPTH + 3));
            if ($urandom_range(0, 15) == 0) a = a | (32'h1 << $urandom_range(7, 31));
            op(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom);
            if ($urandom_range(0, 7) == 0) idle($urandom_range(1, 3));
        end
        rand_bp = 1'b0;
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
